// File: rtl/itlb_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mms_pkg: shared types for the ITLB refill controller.
//   - Width macros `ASID_WD, `VPN0_WD, `VPN1_WD (Sv32 defaults unless the
//     build supplies its own values).
//   - `D_FLIP_FLOP(q, d, rst_val, clk, rstn): one register (or packed struct
//     of registers) with synchronous active-low reset.
//   - itlb_refill_state_e : controller FSM states.
//   - vpn_t / pte_t       : Sv32 virtual page number and leaf PTE layouts.
//   - itlb_refill_regs_t  : every FSM-owned register bundled into one struct
//                           so the whole FSM updates in a single always_ff.
// -----------------------------------------------------------------------------
`ifndef ASID_WD
`define ASID_WD 9
`endif
`ifndef VPN0_WD
`define VPN0_WD 10
`endif
`ifndef VPN1_WD
`define VPN1_WD 10
`endif
`ifndef D_FLIP_FLOP
`define D_FLIP_FLOP(q, d, rst_val, clk, rstn) always_ff @(posedge clk) begin if (!(rstn)) q <= rst_val; else q <= d; end
`endif

package mms_pkg;

    localparam int ASID_WD = `ASID_WD;
    localparam int VPN_WD  = `VPN0_WD + `VPN1_WD;
    localparam int PTE_WD  = 32;

    // IDLE must stay encoded as zero: the register bundle resets to all-zero.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FILL  = 3'd3,
        DRAIN = 3'd4
    } itlb_refill_state_e;

    typedef struct packed {
        logic [`VPN1_WD-1:0] vpn1;
        logic [`VPN0_WD-1:0] vpn0;
    } vpn_t;

    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        itlb_refill_state_e  state;
        logic [ASID_WD-1:0]  asid;
        vpn_t                vpn;
        pte_t                pte;
        logic                fault;
    } itlb_refill_regs_t;

endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// itlb_refill_ctrl_if: lookup, page-table-walk and entry-write signals of the
// ITLB refill controller.
//   modport slave  : the controller's view (itlb_refill_ctrl).
//   modport master : the surrounding ITLB / walker view.
// Signals keep their _i/_o names as seen from the controller.
//   tlb_flush_i, lookup_valid_i/ready_o, lookup_asid_i, lookup_vpn_i,
//   hit_vec_i, miss_o, ptw_req_valid_o/ready_i, ptw_req_asid_o, ptw_req_vpn_o,
//   ptw_resp_valid_i, ptw_resp_pte_i, ptw_resp_err_i, entry_we_o,
//   entry_asid_o, entry_vpn_o, entry_pte_o, entry_g_o, fault_o.
// -----------------------------------------------------------------------------
interface itlb_refill_ctrl_if #(
    parameter int ENTRY_NUM = 8
) ();
    import mms_pkg::*;

    logic                  tlb_flush_i;
    logic                  lookup_valid_i;
    logic                  lookup_ready_o;
    logic [ASID_WD-1:0]    lookup_asid_i;
    vpn_t                  lookup_vpn_i;
    logic [ENTRY_NUM-1:0]  hit_vec_i;
    logic                  miss_o;

    logic                  ptw_req_valid_o;
    logic                  ptw_req_ready_i;
    logic [ASID_WD-1:0]    ptw_req_asid_o;
    vpn_t                  ptw_req_vpn_o;
    logic                  ptw_resp_valid_i;
    pte_t                  ptw_resp_pte_i;
    logic                  ptw_resp_err_i;

    logic [ENTRY_NUM-1:0]  entry_we_o;
    logic [ASID_WD-1:0]    entry_asid_o;
    vpn_t                  entry_vpn_o;
    pte_t                  entry_pte_o;
    logic                  entry_g_o;
    logic                  fault_o;

    modport slave (
        input  tlb_flush_i, lookup_valid_i, lookup_asid_i, lookup_vpn_i, hit_vec_i,
               ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_pte_i, ptw_resp_err_i,
        output lookup_ready_o, miss_o, ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o,
               entry_we_o, entry_asid_o, entry_vpn_o, entry_pte_o, entry_g_o, fault_o
    );

    modport master (
        output tlb_flush_i, lookup_valid_i, lookup_asid_i, lookup_vpn_i, hit_vec_i,
               ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_pte_i, ptw_resp_err_i,
        input  lookup_ready_o, miss_o, ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o,
               entry_we_o, entry_asid_o, entry_vpn_o, entry_pte_o, entry_g_o, fault_o
    );

endinterface

// File: rtl/itlb_refill_ctrl_victim_rr.sv
// -----------------------------------------------------------------------------
// itlb_victim_rr: round-robin victim pointer for ITLB refills.
//   clk_i      : clock
//   rstn_i     : synchronous active-low reset (pointer -> 0)
//   advance_i  : step the pointer after a completed fill
//   victim_o   : current victim index, $clog2(ENTRY_NUM) bits
// ENTRY_NUM is a power of two >= 2; the pointer wraps ENTRY_NUM-1 -> 0.
// -----------------------------------------------------------------------------
module itlb_victim_rr #(
    parameter  int ENTRY_NUM = 8,
    localparam int PTR_WD    = $clog2(ENTRY_NUM)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              advance_i,
    output logic [PTR_WD-1:0] victim_o
);

    logic [PTR_WD-1:0] ptr_reg;
    logic [PTR_WD-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (advance_i) begin
            ptr_next = (ptr_reg == PTR_WD'(ENTRY_NUM - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    `D_FLIP_FLOP(ptr_reg, ptr_next, '0, clk_i, rstn_i)

    assign victim_o = ptr_reg;

endmodule

// File: rtl/itlb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// itlb_refill_ctrl: ITLB miss handler.
//   On a lookup miss it captures ASID/VPN, requests a page-table walk, and on a
//   good response writes the translation into a round-robin victim entry.
//   Lookups are stalled (lookup_ready_o=0) while a refill is in flight.
// Ports:
//   clk_i       : clock
//   rstn_i      : synchronous active-low reset
//   bus         : itlb_refill_ctrl_if.slave (lookup, PTW req/resp, entry write)
//   miss_cnt_o  : saturating accepted-miss counter, only when the macro
//                 ITLB_PERF_CNT_EN is defined
// Latency: miss in N -> ptw_req_valid_o in N+1; good response in M ->
//   entry_we_o in M+1, lookup_ready_o again in M+2.
// tlb_flush_i has priority over everything and never resets the victim.
// -----------------------------------------------------------------------------
module itlb_refill_ctrl #(
    parameter int ENTRY_NUM = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    itlb_refill_ctrl_if.slave     bus
`ifdef ITLB_PERF_CNT_EN
    ,
    output logic [31:0]           miss_cnt_o
`endif
);
    import mms_pkg::*;

    localparam int PTR_WD = $clog2(ENTRY_NUM);

    itlb_refill_regs_t    regs_reg;
    itlb_refill_regs_t    regs_next;
    logic                 lookup_ready;
    logic                 miss;
    logic                 fill_fire;
    logic [PTR_WD-1:0]    victim;
    logic [ENTRY_NUM-1:0] we_vec;

    // A flush in IDLE blocks acceptance of a same-cycle lookup.
    assign lookup_ready = rstn_i && (regs_reg.state == IDLE) && !bus.tlb_flush_i;
    assign miss         = bus.lookup_valid_i && lookup_ready && !(|bus.hit_vec_i);

    // The write happens in the FILL cycle itself, so a flush (or reset) in
    // that same cycle must be able to cancel it; hence the combinational gate.
    assign fill_fire = rstn_i && (regs_reg.state == FILL) && !bus.tlb_flush_i;

    always_comb begin
        regs_next       = regs_reg;
        regs_next.fault = 1'b0;
        case (regs_reg.state)
            IDLE: begin
                if (miss) begin
                    regs_next.asid  = bus.lookup_asid_i;
                    regs_next.vpn   = bus.lookup_vpn_i;
                    regs_next.state = REQ;
                end
            end
            REQ: begin
                // Request valid is registered, so a flush cannot retract a
                // handshake already happening this cycle: the walker owns the
                // request and its response must be drained.
                if (bus.ptw_req_ready_i) begin
                    regs_next.state = bus.tlb_flush_i ? DRAIN : WAIT;
                end else if (bus.tlb_flush_i) begin
                    regs_next.state = IDLE;
                end
            end
            WAIT: begin
                if (bus.ptw_resp_valid_i) begin
                    if (bus.tlb_flush_i) begin
                        regs_next.state = IDLE;
                    end else if (bus.ptw_resp_err_i) begin
                        regs_next.fault = 1'b1;
                        regs_next.state = IDLE;
                    end else begin
                        regs_next.pte   = bus.ptw_resp_pte_i;
                        regs_next.state = FILL;
                    end
                end else if (bus.tlb_flush_i) begin
                    regs_next.state = DRAIN;
                end
            end
            FILL: begin
                regs_next.state = IDLE;
            end
            DRAIN: begin
                if (bus.ptw_resp_valid_i) begin
                    regs_next.state = IDLE;
                end
            end
            default: begin
                regs_next.state = IDLE;
            end
        endcase
    end

    `D_FLIP_FLOP(regs_reg, regs_next, '0, clk_i, rstn_i)

    itlb_victim_rr #(
        .ENTRY_NUM (ENTRY_NUM)
    ) u_victim_rr (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .advance_i (fill_fire),
        .victim_o  (victim)
    );

    // Expand the binary victim index into the one-hot entry write enable.
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_we
        assign we_vec[gi] = fill_fire && (victim == PTR_WD'(gi));
    end

    assign bus.lookup_ready_o  = lookup_ready;
    assign bus.miss_o          = miss;
    assign bus.ptw_req_valid_o = (regs_reg.state == REQ);
    assign bus.ptw_req_asid_o  = regs_reg.asid;
    assign bus.ptw_req_vpn_o   = regs_reg.vpn;
    assign bus.entry_we_o      = we_vec;
    assign bus.entry_asid_o    = regs_reg.asid;
    assign bus.entry_vpn_o     = regs_reg.vpn;
    assign bus.entry_pte_o     = regs_reg.pte;
    assign bus.entry_g_o       = regs_reg.pte.g;
    assign bus.fault_o         = regs_reg.fault;

`ifdef ITLB_PERF_CNT_EN
    logic [31:0] miss_cnt_reg;
    logic [31:0] miss_cnt_next;

    assign miss_cnt_next = (miss && (miss_cnt_reg != 32'hFFFF_FFFF)) ?
                           miss_cnt_reg + 32'd1 : miss_cnt_reg;

    `D_FLIP_FLOP(miss_cnt_reg, miss_cnt_next, '0, clk_i, rstn_i)

    assign miss_cnt_o = miss_cnt_reg;
`endif

`ifndef SYNTHESIS
    // Several entries matching one lookup means the tag array is corrupt.
    a_hit_onehot0: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (bus.lookup_valid_i && lookup_ready) |-> $onehot0(bus.hit_vec_i));

    // Responses are only meaningful while a walk is outstanding.
    a_resp_window: assert property (@(posedge clk_i) disable iff (!rstn_i)
        bus.ptw_resp_valid_i |-> (regs_reg.state == WAIT || regs_reg.state == DRAIN));
`endif

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_itlb_refill_ctrl: directed bench for itlb_refill_ctrl.
// Stimulus pushes expected walk-request handshakes, entry writes and faults
// into a queue; a negedge monitor pops and compares whenever the DUT shows
// one. The miss-counter section is built only with ITLB_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_itlb_refill_ctrl;
    import mms_pkg::*;

    localparam int N = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    itlb_refill_ctrl_if #(.ENTRY_NUM(N)) bus ();
`ifdef ITLB_PERF_CNT_EN
    logic [31:0] miss_cnt;
`endif

    itlb_refill_ctrl #(.ENTRY_NUM(N)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
`ifdef ITLB_PERF_CNT_EN
        ,
        .miss_cnt_o (miss_cnt)
`endif
    );

    typedef enum int {EV_REQ = 0, EV_WE = 1, EV_FAULT = 2} ev_kind_e;
    typedef struct {
        ev_kind_e     kind;
        logic [127:0] data;
    } ev_t;

    ev_t sb_q[$];
    int  checks     = 0;
    int  errors     = 0;
    int  exp_victim = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_req(input logic [ASID_WD-1:0] asid,
                                             input logic [VPN_WD-1:0] vpn);
        return 128'({asid, vpn});
    endfunction

    function automatic logic [127:0] pack_we(input logic [N-1:0] we, input logic g,
                                            input logic [ASID_WD-1:0] asid,
                                            input logic [VPN_WD-1:0] vpn,
                                            input logic [31:0] pte);
        return 128'({we, g, asid, vpn, pte});
    endfunction

    task automatic observe(input ev_kind_e k, input logic [127:0] d);
        ev_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h, required no event", k, d);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", 128'(k), 128'(e.kind));
            chk("event_data", d, e.data);
            $display("txn kind=%0d data=%0h", k, d);
        end
    endtask

    // Monitor: one comparison set per DUT-visible transaction.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.ptw_req_valid_o && bus.ptw_req_ready_i)
                observe(EV_REQ, pack_req(bus.ptw_req_asid_o, bus.ptw_req_vpn_o));
            if (|bus.entry_we_o)
                observe(EV_WE, pack_we(bus.entry_we_o, bus.entry_g_o, bus.entry_asid_o,
                                       bus.entry_vpn_o, bus.entry_pte_o));
            if (bus.fault_o)
                observe(EV_FAULT, pack_req(bus.ptw_req_asid_o, bus.ptw_req_vpn_o));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a missing lookup for one cycle (state must be IDLE).
    task automatic issue_miss(input logic [ASID_WD-1:0] asid, input logic [VPN_WD-1:0] vpn);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_asid_i  = asid;
        bus.lookup_vpn_i   = vpn;
        bus.hit_vec_i      = '0;
        @(negedge clk);
        chk("miss_o", 128'(bus.miss_o), 128'(1));
        chk("lookup_ready", 128'(bus.lookup_ready_o), 128'(1));
        tick();
        bus.lookup_valid_i = 1'b0;
    endtask

    // Hold ready low for 'delay' cycles, then accept; request must stay stable.
    task automatic handshake(input logic [ASID_WD-1:0] asid, input logic [VPN_WD-1:0] vpn,
                             input int delay);
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                bus.ptw_req_ready_i = 1'b1;
                sb_q.push_back('{kind: EV_REQ, data: pack_req(asid, vpn)});
            end
            @(negedge clk);
            chk("req_valid", 128'(bus.ptw_req_valid_o), 128'(1));
            chk("req_addr", pack_req(bus.ptw_req_asid_o, bus.ptw_req_vpn_o), pack_req(asid, vpn));
            tick();
        end
        bus.ptw_req_ready_i = 1'b0;
    endtask

    task automatic refill(input logic [ASID_WD-1:0] asid, input logic [VPN_WD-1:0] vpn,
                          input int delay, input logic [31:0] pte, input bit err);
        logic [N-1:0] we_exp;
        we_exp = N'(1) << exp_victim;
        issue_miss(asid, vpn);
        handshake(asid, vpn, delay);
        bus.ptw_resp_valid_i = 1'b1;
        bus.ptw_resp_pte_i   = pte;
        bus.ptw_resp_err_i   = err;
        if (err)
            sb_q.push_back('{kind: EV_FAULT, data: pack_req(asid, vpn)});
        else
            sb_q.push_back('{kind: EV_WE, data: pack_we(we_exp, pte[5], asid, vpn, pte)});
        tick();
        bus.ptw_resp_valid_i = 1'b0;
        bus.ptw_resp_err_i   = 1'b0;
        @(negedge clk);
        if (!err) begin
            chk("we_latency", 128'(bus.entry_we_o), 128'(we_exp));
            exp_victim = (exp_victim + 1) % N;
        end else begin
            chk("fault_pulse", 128'(bus.fault_o), 128'(1));
            chk("we_on_fault", 128'(bus.entry_we_o), 128'(0));
        end
        tick();
        @(negedge clk);
        chk("ready_after", 128'(bus.lookup_ready_o), 128'(1));
        chk("fault_single", 128'(bus.fault_o), 128'(0));
        chk("we_single", 128'(bus.entry_we_o), 128'(0));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tlb_flush_i      = 1'b0;
        bus.lookup_valid_i   = 1'b0;
        bus.lookup_asid_i    = '0;
        bus.lookup_vpn_i     = '0;
        bus.hit_vec_i        = '0;
        bus.ptw_req_ready_i  = 1'b0;
        bus.ptw_resp_valid_i = 1'b0;
        bus.ptw_resp_pte_i   = '0;
        bus.ptw_resp_err_i   = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 128'(bus.lookup_ready_o), 128'(0));
        chk("rst_req_valid", 128'(bus.ptw_req_valid_o), 128'(0));
        chk("rst_we", 128'(bus.entry_we_o), 128'(0));
        chk("rst_fault", 128'(bus.fault_o), 128'(0));
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(bus.lookup_ready_o), 128'(1));
        tick();

        // Miss ASID=2 VPN=0x4FF, walker stalls 3 cycles, good PTE -> entry 0
        refill(9'd2, 20'h004FF, 3, 32'h2000_00CF, 1'b0);

        // Lookup that hits: no miss, no request
        bus.lookup_valid_i = 1'b1;
        bus.hit_vec_i      = 8'h04;
        @(negedge clk);
        chk("hit_no_miss", 128'(bus.miss_o), 128'(0));
        tick();
        bus.lookup_valid_i = 1'b0;
        bus.hit_vec_i      = '0;
        @(negedge clk);
        chk("hit_no_req", 128'(bus.ptw_req_valid_o), 128'(0));
        tick();

        // Flush together with a missing lookup in IDLE: not accepted
        bus.lookup_valid_i = 1'b1;
        bus.tlb_flush_i    = 1'b1;
        @(negedge clk);
        chk("flush_ready", 128'(bus.lookup_ready_o), 128'(0));
        chk("flush_miss", 128'(bus.miss_o), 128'(0));
        tick();
        bus.lookup_valid_i = 1'b0;
        bus.tlb_flush_i    = 1'b0;
        @(negedge clk);
        chk("flush_no_req", 128'(bus.ptw_req_valid_o), 128'(0));
        tick();

        // Nine fills: victim walks the remaining entries and wraps
        for (int i = 0; i < 9; i++)
            refill(9'(16 + i), 20'(32'h1000 + i), i % 3, 32'h0000_10EF + (i << 10), 1'b0);

        // Flush in WAIT, response 5 cycles later is drained silently
        issue_miss(9'd5, 20'h00123);
        handshake(9'd5, 20'h00123, 0);
        bus.tlb_flush_i = 1'b1;
        tick();
        bus.tlb_flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_ready", 128'(bus.lookup_ready_o), 128'(0));
            tick();
        end
        bus.ptw_resp_valid_i = 1'b1;
        bus.ptw_resp_pte_i   = 32'h1234_50CF;
        tick();
        bus.ptw_resp_valid_i = 1'b0;
        @(negedge clk);
        chk("drain_no_we", 128'(bus.entry_we_o), 128'(0));
        chk("drain_no_fault", 128'(bus.fault_o), 128'(0));
        chk("drain_idle", 128'(bus.lookup_ready_o), 128'(1));
        tick();

        // Flush in REQ before the walker accepts: request withdrawn
        issue_miss(9'd6, 20'h00456);
        bus.tlb_flush_i = 1'b1;
        tick();
        bus.tlb_flush_i = 1'b0;
        @(negedge clk);
        chk("req_withdrawn", 128'(bus.ptw_req_valid_o), 128'(0));
        chk("req_flush_idle", 128'(bus.lookup_ready_o), 128'(1));
        tick();

        // Flush in the FILL cycle: write suppressed, victim held
        issue_miss(9'd7, 20'h00789);
        handshake(9'd7, 20'h00789, 0);
        bus.ptw_resp_valid_i = 1'b1;
        bus.ptw_resp_pte_i   = 32'h0ABC_00CF;
        tick();
        bus.ptw_resp_valid_i = 1'b0;
        bus.tlb_flush_i      = 1'b1;
        @(negedge clk);
        chk("fill_flush_we", 128'(bus.entry_we_o), 128'(0));
        tick();
        bus.tlb_flush_i = 1'b0;
        @(negedge clk);
        chk("fill_flush_idle", 128'(bus.lookup_ready_o), 128'(1));
        tick();

        // Next fill reuses the victim skipped by both flushes
        refill(9'd8, 20'h00ABC, 1, 32'h0003_00DF, 1'b0);

        // Walk error: fault pulse, no write, victim unchanged
        refill(9'd9, 20'h00DEF, 0, 32'h0000_0000, 1'b1);
        refill(9'd10, 20'h00FED, 0, 32'h0004_00CF, 1'b0);

        // Reset during WAIT: back to IDLE, no write, no fault, victim cleared
        issue_miss(9'd11, 20'h01111);
        handshake(9'd11, 20'h01111, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_victim = 0;
        @(negedge clk);
        chk("rst_mid_req", 128'(bus.ptw_req_valid_o), 128'(0));
        chk("rst_mid_we", 128'(bus.entry_we_o), 128'(0));
        chk("rst_mid_fault", 128'(bus.fault_o), 128'(0));
        chk("rst_mid_ready", 128'(bus.lookup_ready_o), 128'(1));
        tick();
        refill(9'd12, 20'h02222, 0, 32'h0005_00CF, 1'b0);

`ifdef ITLB_PERF_CNT_EN
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_victim = 0;
        @(negedge clk);
        chk("cnt_reset", 128'(miss_cnt), 128'(0));
        tick();
        for (int i = 0; i < 3; i++)
            refill(9'(20 + i), 20'(32'h3000 + i), 0, 32'h0006_00CF, 1'b0);
        @(negedge clk);
        chk("cnt_three", 128'(miss_cnt), 128'(3));
        tick();
        force dut.miss_cnt_reg = 32'hFFFF_FFFF;
        tick();
        release dut.miss_cnt_reg;
        refill(9'd30, 20'h03333, 0, 32'h0007_00CF, 1'b0);
        @(negedge clk);
        chk("cnt_saturate", 128'(miss_cnt), 128'(32'hFFFF_FFFF));
        tick();
`endif

        repeat (3) tick();
        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
